// File: rtl/z80_mem_responder.sv
// z80_mem_responder
//   Memory-side responder for the z80 core bus. CPU reads are served
//   combinationally from a 128 KB array (0 wait states); CPU writes commit on
//   the rising clock edge, subject to ROM write-protect. A host byte-stream
//   loader can fill memory while the CPU is held (cpu_hold gates the CPU
//   clock at the top level).
//
//   Optional feature macro: MEM_BANK_EN
//     defined   : 3-bit bank register loaded by CPU writes to BANK_PORT;
//                 0xC000..0xFFFF map to phys {bank, addr[13:0]}.
//     undefined : flat mapping phys = {1'b0, addr}; BANK_PORT is plain RAM.
//
//   Ports
//     clock         in   system clock, all state on posedge
//     reset         in   synchronous, active-high
//     cpu_address   in   [15:0] CPU bus address
//     cpu_we        in   CPU write strobe
//     cpu_data_w    in   [7:0] CPU write data
//     cpu_data_r    out  [7:0] read data, combinational from cpu_address
//     cpu_hold      out  1 while the loader owns memory
//     ld_valid      in   host byte valid
//     ld_ready      out  responder accepts a byte this cycle
//     ld_data       in   [7:0] host byte
//     ld_done       out  1-cycle pulse when a load frame completes
//     ld_state_dbg  out  [2:0] loader FSM state (debug visibility)
//
//   Loader handshake: a byte transfers on a rising edge where
//   ld_valid && ld_ready are both 1; ld_ready depends only on FSM state, never
//   on ld_valid, and the host must hold ld_data stable while ld_valid is high.
//   Frame format: A5, addr_lo, addr_hi, len_lo, len_hi, len data bytes.

module z80_mem_responder #(
    parameter logic [15:0] ROM_TOP     = 16'h3FFF,
    parameter int          ROM_PROTECT = 1,
    parameter logic [15:0] BANK_PORT   = 16'h7FFD
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cpu_address,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_data_w,
    output logic [7:0]  cpu_data_r,
    output logic        cpu_hold,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [7:0]  ld_data,
    output logic        ld_done,
    output logic [2:0]  ld_state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AL   = 3'd1,
        S_AH   = 3'd2,
        S_NL   = 3'd3,
        S_NH   = 3'd4,
        S_DATA = 3'd5,
        S_DONE = 3'd6
    } ld_state_e;

    localparam logic [7:0] CMD_LOAD = 8'hA5;

    logic [7:0] mem [0:131071];

    ld_state_e   state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] len_q, len_d;

    logic        ld_accept;
    logic        ld_wr;
    logic        cpu_protected;
    logic        cpu_wr;
    logic        mem_we;
    logic [16:0] mem_waddr;
    logic [7:0]  mem_wdata;
    logic [16:0] cpu_phys;
    logic [16:0] ld_phys;

`ifdef MEM_BANK_EN
    logic [2:0] bank_q, bank_d;

    // Upper 16 KB window is banked; banks 0..2 deliberately alias the fixed pages.
    function automatic logic [16:0] map_addr(input logic [15:0] a, input logic [2:0] bk);
        if (a[15:14] == 2'b11) begin
            return {bk, a[13:0]};
        end
        return {1'b0, a};
    endfunction

    assign cpu_phys = map_addr(cpu_address, bank_q);
    assign ld_phys  = map_addr(addr_q, bank_q);

    always_comb begin
        bank_d = bank_q;
        if (cpu_wr && (cpu_address == BANK_PORT)) begin
            bank_d = cpu_data_w[2:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bank_q <= 3'd0;
        end else begin
            bank_q <= bank_d;
        end
    end
`else
    logic unused_bank_port;
    assign unused_bank_port = ^BANK_PORT;

    assign cpu_phys = {1'b0, cpu_address};
    assign ld_phys  = {1'b0, addr_q};
`endif

    // ---------------- loader FSM: state register ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= 16'd0;
            len_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
        end
    end

    assign ld_accept = ld_valid && ld_ready;

    // ---------------- loader FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        ld_wr   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Non-command bytes are swallowed so the host can resync.
                if (ld_accept && (ld_data == CMD_LOAD)) begin
                    state_d = S_AL;
                end
            end
            S_AL: begin
                if (ld_accept) begin
                    addr_d[7:0] = ld_data;
                    state_d     = S_AH;
                end
            end
            S_AH: begin
                if (ld_accept) begin
                    addr_d[15:8] = ld_data;
                    state_d      = S_NL;
                end
            end
            S_NL: begin
                if (ld_accept) begin
                    len_d[7:0] = ld_data;
                    state_d    = S_NH;
                end
            end
            S_NH: begin
                if (ld_accept) begin
                    len_d[15:8] = ld_data;
                    // Zero-length frame skips DATA entirely.
                    state_d = ({ld_data, len_q[7:0]} == 16'd0) ? S_DONE : S_DATA;
                end
            end
            S_DATA: begin
                if (ld_accept) begin
                    ld_wr  = 1'b1;
                    addr_d = addr_q + 16'd1;
                    len_d  = len_q - 16'd1;
                    if (len_q == 16'd1) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- loader FSM: outputs ----------------
    always_comb begin
        cpu_hold     = (state_q != S_IDLE);
        ld_ready     = (state_q != S_DONE);
        ld_done      = (state_q == S_DONE);
        ld_state_dbg = state_q;
    end

    // ---------------- memory write arbitration ----------------
    // CPU writes are dropped while held, so the loader and the CPU never
    // reach the array in the same cycle; the loader also bypasses protect.
    assign cpu_protected = (ROM_PROTECT != 0) && (cpu_address <= ROM_TOP);
    assign cpu_wr        = cpu_we && !cpu_hold && !cpu_protected;

    always_comb begin
        mem_we    = !reset && (ld_wr || cpu_wr);
        mem_waddr = cpu_phys;
        mem_wdata = cpu_data_w;
        if (ld_wr) begin
            mem_waddr = ld_phys;
            mem_wdata = ld_data;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign cpu_data_r = mem[cpu_phys];

endmodule

// File: tb/tb_z80_mem_responder.sv
module tb_z80_mem_responder;

    logic        clock;
    logic        reset;
    logic [15:0] cpu_address;
    logic        cpu_we;
    logic [7:0]  cpu_data_w;
    logic [7:0]  cpu_data_r;
    logic        cpu_hold;
    logic        ld_valid;
    logic        ld_ready;
    logic [7:0]  ld_data;
    logic        ld_done;
    logic [2:0]  ld_state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    z80_mem_responder dut (
        .clock        (clock),
        .reset        (reset),
        .cpu_address  (cpu_address),
        .cpu_we       (cpu_we),
        .cpu_data_w   (cpu_data_w),
        .cpu_data_r   (cpu_data_r),
        .cpu_hold     (cpu_hold),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_data      (ld_data),
        .ld_done      (ld_done),
        .ld_state_dbg (ld_state_dbg)
    );

    // ---------------- clock ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_address = a;
        cpu_data_w  = d;
        cpu_we      = 1'b1;
        tick();
        cpu_we      = 1'b0;
    endtask

    task automatic cpu_read_check(input string tag, input logic [15:0] a, input logic [7:0] exp);
        cpu_address = a;
        #1;
        check(tag, {24'd0, cpu_data_r}, {24'd0, exp});
    endtask

    task automatic ld_send(input logic [7:0] b);
        int waits;
        waits    = 0;
        ld_valid = 1'b1;
        ld_data  = b;
        #1;
        while (!ld_ready && waits < 8) begin
            tick();
            waits++;
        end
        if (!ld_ready) begin
            check("ld_ready_timeout", 32'd0, 32'd1);
        end
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic ld_frame(input logic [15:0] a, input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input int n);
        ld_send(8'hA5);
        ld_send(a[7:0]);
        ld_send(a[15:8]);
        ld_send(8'(n));
        ld_send(8'h00);
        if (n > 0) ld_send(d0);
        if (n > 1) ld_send(d1);
        if (n > 2) ld_send(d2);
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset       = 1'b1;
        cpu_address = 16'h0000;
        cpu_we      = 1'b0;
        cpu_data_w  = 8'h00;
        ld_valid    = 1'b0;
        ld_data     = 8'h00;
        tick();
        tick();
        check("rst_hold",  {31'd0, cpu_hold}, 32'd0);
        check("rst_ready", {31'd0, ld_ready}, 32'd1);
        check("rst_done",  {31'd0, ld_done},  32'd0);
        check("rst_state", {29'd0, ld_state_dbg}, 32'd0);
        reset = 1'b0;
        tick();

        // CPU write / same-cycle read.
        cpu_write(16'h8000, 8'h5A);
        cpu_read_check("rd_8000", 16'h8000, 8'h5A);
        cpu_write(16'h4000, 8'h66);
        cpu_read_check("rd_4000_above_rom", 16'h4000, 8'h66);
        cpu_read_check("rd_8000_again", 16'h8000, 8'h5A);

        // Non-command byte in IDLE is discarded.
        ld_send(8'h33);
        check("junk_hold",  {31'd0, cpu_hold}, 32'd0);
        check("junk_state", {29'd0, ld_state_dbg}, 32'd0);

        // Loader frame into ROM; hold rises the cycle after A5.
        check("pre_a5_hold", {31'd0, cpu_hold}, 32'd0);
        ld_send(8'hA5);
        check("post_a5_hold",  {31'd0, cpu_hold}, 32'd1);
        check("post_a5_state", {29'd0, ld_state_dbg}, 32'd1);
        ld_send(8'h00);
        ld_send(8'h01);
        ld_send(8'h03);
        ld_send(8'h00);
        check("hdr_hold", {31'd0, cpu_hold}, 32'd1);
        ld_send(8'hDE);
        ld_send(8'hAD);
        ld_send(8'hBE);
        check("f1_done",  {31'd0, ld_done},  32'd1);
        check("f1_hold",  {31'd0, cpu_hold}, 32'd1);
        check("f1_ready", {31'd0, ld_ready}, 32'd0);
        tick();
        check("f1_done_clr", {31'd0, ld_done},  32'd0);
        check("f1_hold_clr", {31'd0, cpu_hold}, 32'd0);
        cpu_read_check("rd_0100", 16'h0100, 8'hDE);
        cpu_read_check("rd_0101", 16'h0101, 8'hAD);
        cpu_read_check("rd_0102", 16'h0102, 8'hBE);

        // ROM protect, including the top boundary.
        cpu_write(16'h0100, 8'h11);
        cpu_read_check("rom_0100", 16'h0100, 8'hDE);
        ld_frame(16'h3FFF, 8'hC3, 8'h00, 8'h00, 1);
        cpu_write(16'h3FFF, 8'h00);
        cpu_read_check("rom_3fff", 16'h3FFF, 8'hC3);

        // Address wrap FFFF -> 0000.
        ld_frame(16'hFFFF, 8'h11, 8'h22, 8'h00, 2);
        cpu_read_check("wrap_ffff", 16'hFFFF, 8'h11);
        cpu_read_check("wrap_0000", 16'h0000, 8'h22);

        // Zero-length frame: NH goes straight to DONE.
        cpu_write(16'h9000, 8'h44);
        ld_send(8'hA5);
        ld_send(8'h00);
        ld_send(8'h90);
        ld_send(8'h00);
        ld_send(8'h00);
        check("zl_done",  {31'd0, ld_done}, 32'd1);
        check("zl_state", {29'd0, ld_state_dbg}, 32'd6);
        tick();
        check("zl_done_clr", {31'd0, ld_done}, 32'd0);
        cpu_read_check("zl_9000", 16'h9000, 8'h44);

        // Reset mid-frame after 2 of 5 data bytes.
        for (int i = 0; i < 5; i++) cpu_write(16'h8100 + 16'(i), 8'hF0 + 8'(i));
        cpu_write(16'h8200, 8'h55);
        ld_send(8'hA5);
        ld_send(8'h00);
        ld_send(8'h81);
        ld_send(8'h05);
        ld_send(8'h00);
        // CPU write colliding with a loader byte to the same address.
        cpu_address = 16'h8100;
        cpu_data_w  = 8'hEE;
        cpu_we      = 1'b1;
        ld_send(8'h01);
        cpu_we      = 1'b0;
        cpu_write(16'h8200, 8'h99);
        ld_send(8'h02);
        check("mid_state", {29'd0, ld_state_dbg}, 32'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_hold",  {31'd0, cpu_hold}, 32'd0);
        check("mr_ready", {31'd0, ld_ready}, 32'd1);
        check("mr_state", {29'd0, ld_state_dbg}, 32'd0);
        cpu_read_check("mr_8100", 16'h8100, 8'h01);
        cpu_read_check("mr_8101", 16'h8101, 8'h02);
        cpu_read_check("mr_8102", 16'h8102, 8'hF2);
        cpu_read_check("mr_8103", 16'h8103, 8'hF3);
        cpu_read_check("mr_8104", 16'h8104, 8'hF4);
        cpu_read_check("mr_8200_held_write", 16'h8200, 8'h55);

        // Upper window and BANK_PORT.
`ifdef MEM_BANK_EN
        cpu_write(16'h7FFD, 8'h05);
        cpu_write(16'hC000, 8'h77);
        cpu_read_check("bank5_c000", 16'hC000, 8'h77);
        cpu_write(16'h7FFD, 8'h00);
        cpu_read_check("bank0_c000", 16'hC000, 8'h22);
        cpu_read_check("bank_port_ram", 16'h7FFD, 8'h00);
        cpu_write(16'h7FFD, 8'h05);
        cpu_read_check("bank5_c000_back", 16'hC000, 8'h77);
`else
        cpu_write(16'hC000, 8'h77);
        cpu_write(16'h7FFD, 8'h05);
        cpu_read_check("flat_c000", 16'hC000, 8'h77);
        cpu_read_check("flat_7ffd", 16'h7FFD, 8'h05);
        cpu_read_check("flat_0000", 16'h0000, 8'h22);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
